// File: rtl/qspi_target.sv
// Quad-SPI memory target: turns 0xEB (read) and 0x32 (write) serial commands into
// word-wide local memory strobes. The SPI pins are oversampled on aclk, so every
// serial event is handled as a single-cycle edge pulse.
module qspi_target #(
    parameter int unsigned AW           = 10,
    parameter int unsigned DW           = 32,
    parameter int unsigned SPI_W        = 4,
    parameter int unsigned DUMMY_CYCLES = 4
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             SCK,
    input  logic             CSn,
    input  logic [SPI_W-1:0] MOSI,
    output logic [SPI_W-1:0] MISO,
    output logic             miso_oe,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_rd,
    input  logic [DW-1:0]    mem_rdata,
    output logic             mem_wr,
    output logic [DW-1:0]    mem_wdata,
    output logic             busy
);

    localparam int unsigned CW         = 8;
    localparam int unsigned CMD_EDGES  = 8 / SPI_W;
    localparam int unsigned ADDR_EDGES = 24 / SPI_W;
    localparam int unsigned NIB        = DW / SPI_W;

    typedef enum logic [2:0] {
        StIdle, StCmd, StAddr, StDummy, StRData, StWData, StIgnore
    } state_e;

    state_e             r_state;
    logic               r_sck_s1, r_sck_s2, r_sck_d;
    logic               r_csn_s1, r_csn_s2, r_csn_d;
    logic [SPI_W-1:0]   r_mosi_s1, r_mosi_s2;
    logic [CW-1:0]      r_cnt, r_ocnt;
    logic [23-SPI_W:0]  r_shift;
    logic [DW-SPI_W-1:0] r_wshift;
    logic [DW-1:0]      r_rshift, r_hold, r_mem_wdata;
    logic               r_is_read, r_rd_d, r_inc_pend;
    logic [SPI_W-1:0]   r_miso;
    logic               r_miso_oe, r_mem_rd, r_mem_wr;
    logic [AW-1:0]      r_mem_addr;

    logic               w_sck_rise, w_sck_fall, w_csn_fall;
    logic [23:0]        w_shift_nx;
    logic [DW-1:0]      w_wshift_nx;
    logic               w_unused;

    assign w_sck_rise  = r_sck_s2 & ~r_sck_d;
    assign w_sck_fall  = ~r_sck_s2 & r_sck_d;
    // Sync regs clear to 0, so a CSn already low when reset releases gives no edge.
    assign w_csn_fall  = ~r_csn_s2 & r_csn_d;
    assign w_shift_nx  = {r_shift, r_mosi_s2};
    assign w_wshift_nx = {r_wshift, r_mosi_s2};
    assign w_unused    = ^{w_shift_nx[23:AW+2], w_shift_nx[1:0]};

    assign MISO      = r_miso;
    assign miso_oe   = r_miso_oe;
    assign mem_addr  = r_mem_addr;
    assign mem_rd    = r_mem_rd;
    assign mem_wr    = r_mem_wr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != StIdle);

    // Two-flop synchronizers plus one delay stage for edge detection.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_sck_s1  <= 1'b0;
            r_sck_s2  <= 1'b0;
            r_sck_d   <= 1'b0;
            r_csn_s1  <= 1'b0;
            r_csn_s2  <= 1'b0;
            r_csn_d   <= 1'b0;
            r_mosi_s1 <= '0;
            r_mosi_s2 <= '0;
        end else begin
            r_sck_s1  <= SCK;
            r_sck_s2  <= r_sck_s1;
            r_sck_d   <= r_sck_s2;
            r_csn_s1  <= CSn;
            r_csn_s2  <= r_csn_s1;
            r_csn_d   <= r_csn_s2;
            r_mosi_s1 <= MOSI;
            r_mosi_s2 <= r_mosi_s1;
        end
    end

    // Protocol FSM with registered outputs, read prefetch and write assembly.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_ocnt      <= '0;
            r_shift     <= '0;
            r_wshift    <= '0;
            r_rshift    <= '0;
            r_hold      <= '0;
            r_is_read   <= 1'b0;
            r_rd_d      <= 1'b0;
            r_inc_pend  <= 1'b0;
            r_miso      <= '0;
            r_miso_oe   <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_rd_d   <= r_mem_rd;
            if (r_rd_d) begin
                r_hold <= mem_rdata;
            end
            // Write address advances the cycle after the mem_wr strobe.
            if (r_inc_pend) begin
                r_mem_addr <= r_mem_addr + AW'(1);
                r_inc_pend <= 1'b0;
            end
            if (r_csn_s2) begin
                // Deselected: abort whatever is in flight, partial words are dropped.
                r_state   <= StIdle;
                r_miso    <= '0;
                r_miso_oe <= 1'b0;
                r_cnt     <= '0;
                r_ocnt    <= '0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (w_csn_fall) begin
                            r_state <= StCmd;
                            r_cnt   <= '0;
                            r_shift <= '0;
                        end
                    end
                    StCmd: begin
                        if (w_sck_rise) begin
                            r_shift <= w_shift_nx[23-SPI_W:0];
                            if (r_cnt == CW'(CMD_EDGES - 1)) begin
                                r_cnt <= '0;
                                if (w_shift_nx[7:0] == 8'hEB) begin
                                    r_is_read <= 1'b1;
                                    r_state   <= StAddr;
                                end else if (w_shift_nx[7:0] == 8'h32) begin
                                    r_is_read <= 1'b0;
                                    r_state   <= StAddr;
                                end else begin
                                    r_state <= StIgnore;
                                end
                            end else begin
                                r_cnt <= r_cnt + CW'(1);
                            end
                        end
                    end
                    StAddr: begin
                        if (w_sck_rise) begin
                            r_shift <= w_shift_nx[23-SPI_W:0];
                            if (r_cnt == CW'(ADDR_EDGES - 1)) begin
                                r_cnt      <= '0;
                                r_ocnt     <= '0;
                                r_mem_addr <= w_shift_nx[AW+1:2];
                                if (r_is_read) begin
                                    r_mem_rd <= 1'b1;
                                    if (DUMMY_CYCLES == 0) begin
                                        r_state   <= StRData;
                                        r_miso_oe <= 1'b1;
                                    end else begin
                                        r_state <= StDummy;
                                    end
                                end else begin
                                    r_state <= StWData;
                                end
                            end else begin
                                r_cnt <= r_cnt + CW'(1);
                            end
                        end
                    end
                    StDummy: begin
                        if (w_sck_rise) begin
                            if (r_cnt == CW'(DUMMY_CYCLES - 1)) begin
                                r_cnt     <= '0;
                                r_state   <= StRData;
                                r_miso_oe <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + CW'(1);
                            end
                        end
                    end
                    StRData: begin
                        r_miso_oe <= 1'b1;
                        // Word boundary on the output side pulls from the holding register.
                        if (w_sck_fall) begin
                            if (r_ocnt == '0) begin
                                r_miso   <= r_hold[DW-1 -: SPI_W];
                                r_rshift <= r_hold << SPI_W;
                            end else begin
                                r_miso   <= r_rshift[DW-1 -: SPI_W];
                                r_rshift <= r_rshift << SPI_W;
                            end
                            r_ocnt <= (r_ocnt == CW'(NIB - 1)) ? '0 : r_ocnt + CW'(1);
                        end
                        // Last nibble sampled by the initiator: prefetch the next word.
                        if (w_sck_rise) begin
                            if (r_cnt == CW'(NIB - 1)) begin
                                r_cnt      <= '0;
                                r_mem_addr <= r_mem_addr + AW'(1);
                                r_mem_rd   <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + CW'(1);
                            end
                        end
                    end
                    StWData: begin
                        if (w_sck_rise) begin
                            r_wshift <= w_wshift_nx[DW-SPI_W-1:0];
                            if (r_cnt == CW'(NIB - 1)) begin
                                r_cnt       <= '0;
                                r_mem_wdata <= w_wshift_nx;
                                r_mem_wr    <= 1'b1;
                                r_inc_pend  <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + CW'(1);
                            end
                        end
                    end
                    StIgnore: begin
                        r_miso_oe <= 1'b0;
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qspi_target.sv
// Directed bench for qspi_target: read, write burst, address wrap, abort,
// unknown command and reset-during-read, against a small memory model.
module tb_qspi_target;

    logic        aclk = 1'b0;
    logic        areset, SCK, CSn;
    logic [3:0]  MOSI;
    logic [3:0]  MISO;
    logic        miso_oe, mem_rd, mem_wr, busy;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata, mem_wdata;

    qspi_target dut (
        .aclk      (aclk),
        .areset    (areset),
        .SCK       (SCK),
        .CSn       (CSn),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .miso_oe   (miso_oe),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .busy      (busy)
    );

    always #5 aclk = ~aclk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          rd_cnt, wr_cnt, oe_cnt, both_cnt;
    logic [9:0]  rd_addr_log [0:7];
    logic [9:0]  wr_addr_log [0:7];
    logic [31:0] wr_data_log [0:7];
    logic [31:0] mem [0:1023];
    logic [63:0] rd_acc;

    // Memory answers a read strobe one aclk later.
    always @(posedge aclk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    // Strobe logging on the falling edge, away from DUT updates.
    always @(negedge aclk) begin
        if (mem_rd) begin
            if (rd_cnt < 8) rd_addr_log[rd_cnt] = mem_addr;
            rd_cnt = rd_cnt + 1;
        end
        if (mem_wr) begin
            if (wr_cnt < 8) begin
                wr_addr_log[wr_cnt] = mem_addr;
                wr_data_log[wr_cnt] = mem_wdata;
            end
            wr_cnt = wr_cnt + 1;
        end
        if (miso_oe) oe_cnt = oe_cnt + 1;
        if (mem_rd && mem_wr) both_cnt = both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr_logs();
        rd_cnt = 0;
        wr_cnt = 0;
        oe_cnt = 0;
    endtask

    // One SCK period: drive MOSI while low, sample MISO just before the rise.
    task automatic sck_cycle(input logic [3:0] nib, output logic [3:0] seen);
        MOSI = nib;
        #80;
        seen = MISO;
        SCK = 1'b1;
        #80;
        SCK = 1'b0;
    endtask

    task automatic send(input logic [31:0] v, input int n);
        logic [3:0] s;
        for (int i = n - 1; i >= 0; i--) sck_cycle(v[4*i +: 4], s);
    endtask

    task automatic start_cmd(input logic [7:0] cmd, input logic [23:0] addr);
        CSn = 1'b0;
        #50;
        send({24'h0, cmd}, 2);
        send({8'h0, addr}, 6);
    endtask

    // Dummy cycles followed by nnib data nibbles collected into rd_acc.
    task automatic read_data(input int nnib);
        logic [3:0] s;
        rd_acc = '0;
        send(32'h0, 4);
        for (int i = 0; i < nnib; i++) begin
            sck_cycle(4'h0, s);
            rd_acc = {rd_acc[59:0], s};
        end
    endtask

    task automatic end_cs();
        #40;
        CSn = 1'b1;
        #200;
    endtask

    initial begin
        areset = 1'b1;
        SCK    = 1'b0;
        CSn    = 1'b1;
        MOSI   = 4'h0;
        both_cnt = 0;
        clr_logs();
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[10'h004] = 32'hDEADBEEF;
        mem[10'h005] = 32'h01234567;
        mem[10'h3FF] = 32'hA5A5A5A5;
        mem[10'h000] = 32'h5A5A5A5A;
        #30;
        check("rst_miso",    {28'h0, MISO}, 32'h0);
        check("rst_oe",      {31'h0, miso_oe}, 32'h0);
        check("rst_addr",    {22'h0, mem_addr}, 32'h0);
        check("rst_rd",      {31'h0, mem_rd}, 32'h0);
        check("rst_wr",      {31'h0, mem_wr}, 32'h0);
        check("rst_wdata",   mem_wdata, 32'h0);
        check("rst_busy",    {31'h0, busy}, 32'h0);
        areset = 1'b0;
        #50;

        // Single-word read at byte address 0x10.
        clr_logs();
        start_cmd(8'hEB, 24'h000010);
        read_data(8);
        check("rd_oe",       {31'h0, miso_oe}, 32'h1);
        check("rd_busy",     {31'h0, busy}, 32'h1);
        check("rd_data",     rd_acc[31:0], 32'hDEADBEEF);
        check("rd_addr",     {22'h0, rd_addr_log[0]}, 32'h004);
        end_cs();
        check("rd_end_busy", {31'h0, busy}, 32'h0);
        check("rd_end_oe",   {31'h0, miso_oe}, 32'h0);

        // Two-word read crossing the top of the word space.
        clr_logs();
        start_cmd(8'hEB, 24'h000FFC);
        read_data(16);
        check("wrap_w0",     rd_acc[63:32], 32'hA5A5A5A5);
        check("wrap_w1",     rd_acc[31:0], 32'h5A5A5A5A);
        check("wrap_a0",     {22'h0, rd_addr_log[0]}, 32'h3FF);
        check("wrap_a1",     {22'h0, rd_addr_log[1]}, 32'h000);
        end_cs();

        // Two-word write burst.
        clr_logs();
        start_cmd(8'h32, 24'h000000);
        send(32'h12345678, 8);
        send(32'hCAFEF00D, 8);
        end_cs();
        check("wr_cnt",      wr_cnt, 2);
        check("wr_a0",       {22'h0, wr_addr_log[0]}, 32'h000);
        check("wr_d0",       wr_data_log[0], 32'h12345678);
        check("wr_a1",       {22'h0, wr_addr_log[1]}, 32'h001);
        check("wr_d1",       wr_data_log[1], 32'hCAFEF00D);
        check("wr_no_rd",    rd_cnt, 0);
        check("wr_no_oe",    oe_cnt, 0);

        // Write aborted after five data nibbles.
        clr_logs();
        start_cmd(8'h32, 24'h000040);
        send(32'h00012345, 5);
        check("ab_busy_pre", {31'h0, busy}, 32'h1);
        CSn = 1'b1;
        #40;
        check("ab_busy",     {31'h0, busy}, 32'h0);
        check("ab_oe",       {31'h0, miso_oe}, 32'h0);
        #200;
        check("ab_no_wr",    wr_cnt, 0);

        // Unknown command followed by 16 more SCK cycles.
        clr_logs();
        CSn = 1'b0;
        #50;
        send(32'h9F, 2);
        send(32'hEB32EB32, 8);
        send(32'hFFFFFFFF, 8);
        check("ign_busy",    {31'h0, busy}, 32'h1);
        end_cs();
        check("ign_no_rd",   rd_cnt, 0);
        check("ign_no_wr",   wr_cnt, 0);
        check("ign_no_oe",   oe_cnt, 0);

        // Reset in the middle of a read, then a clean read afterwards.
        clr_logs();
        start_cmd(8'hEB, 24'h000010);
        read_data(3);
        check("rr_pre_oe",   {31'h0, miso_oe}, 32'h1);
        #20;
        areset = 1'b1;
        #10;
        check("rr_miso",     {28'h0, MISO}, 32'h0);
        check("rr_oe",       {31'h0, miso_oe}, 32'h0);
        check("rr_busy",     {31'h0, busy}, 32'h0);
        check("rr_addr",     {22'h0, mem_addr}, 32'h0);
        check("rr_rd",       {31'h0, mem_rd}, 32'h0);
        #20;
        areset = 1'b0;
        #50;
        send(32'hEB, 2);
        check("rr_stale_cs", {31'h0, busy}, 32'h0);
        CSn = 1'b1;
        #200;
        clr_logs();
        start_cmd(8'hEB, 24'h000010);
        read_data(8);
        check("rr_data",     rd_acc[31:0], 32'hDEADBEEF);
        check("rr_rd_addr",  {22'h0, rd_addr_log[0]}, 32'h004);
        end_cs();

        check("no_rd_wr_overlap", both_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
